// File: rtl/row_buf_pkg.sv
`default_nettype none
// ============================================================================
// Module      : row_buf_pkg
// Description : Shared types and sizing helpers for the row-buffer writer
//               and the row-buffer controller.
// Revision    : 1.0 - initial release
// ============================================================================
package row_buf_pkg;

    localparam int PIX_WIDTH = 8;

    typedef logic [PIX_WIDTH-1:0] pixel_t;

    typedef enum logic [1:0] {
        WR_IDLE  = 2'd0,
        WR_WRITE = 2'd1,
        WR_FLUSH = 2'd2,
        WR_DONE  = 2'd3
    } wr_state_e;

    // Round value up to the next multiple of mult.
    function automatic int f_ceil(input int value, input int mult);
        return ((value + mult - 1) / mult) * mult;
    endfunction

    function automatic int f_ram_count(input int hint, input int last_iw);
        return hint / last_iw;
    endfunction

endpackage
`default_nettype wire

// File: rtl/row_pixel_mask.sv
`default_nettype none
// ============================================================================
// Module      : row_pixel_mask
// Description : Combinational per-lane column padding and optional ReLU
//               (enabled by macro ROW_WRITER_RELU_EN) for one stream beat.
// Revision    : 1.0 - initial release
// ============================================================================
module row_pixel_mask
    import row_buf_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int LAST_Iw    = 7,
    parameter int REAL_HINT  = 56,
    parameter int RAM_COUNT  = 8,
    parameter int GRP_WIDTH  = 3
) (
    input  logic [GRP_WIDTH-1:0]          i_grp,
    input  logic [LAST_Iw*DATA_WIDTH-1:0] i_data,
    output logic [LAST_Iw*DATA_WIDTH-1:0] o_data
);

    for (genvar l = 0; l < LAST_Iw; l++) begin : g_lane
        logic                  w_pad;
        logic [DATA_WIDTH-1:0] w_pix;

        // Lanes past the true row width only exist in the last RAM group.
        assign w_pad = (int'(i_grp) == RAM_COUNT - 1) &&
                       ((int'(i_grp) * LAST_Iw + l) >= REAL_HINT);
        assign w_pix = w_pad ? '0 : i_data[l*DATA_WIDTH +: DATA_WIDTH];

`ifdef ROW_WRITER_RELU_EN
        assign o_data[l*DATA_WIDTH +: DATA_WIDTH] = w_pix[DATA_WIDTH-1] ? '0 : w_pix;
`else
        assign o_data[l*DATA_WIDTH +: DATA_WIDTH] = w_pix;
`endif
    end : g_lane

endmodule
`default_nettype wire

// File: rtl/row_buffer_writer.sv
`default_nettype none
// ============================================================================
// Module      : row_buffer_writer
// Description : Writes one channel-major row of stream beats into the row
//               buffer RAMs; optional ReLU via macro ROW_WRITER_RELU_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module row_buffer_writer
    import row_buf_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int REAL_HINT  = 56,
    parameter int LAST_Iw    = 7,
    parameter int LAST_C     = 256,
    parameter int HINT       = f_ceil(REAL_HINT, LAST_Iw),
    parameter int RAM_COUNT  = HINT / LAST_Iw,
    parameter int ADDR_WIDTH = 32,
    parameter int CH_WIDTH   = 10
) (
    input  logic                                     clk,
    input  logic                                     rstn,
    input  logic                                     buffer_writer_en,
    output logic                                     buffer_writer_done,
    input  logic                                     in_valid,
    output logic                                     in_ready,
    input  logic [LAST_Iw*DATA_WIDTH-1:0]            in_data,
    input  logic                                     in_last,
    output logic [RAM_COUNT-1:0]                     buffer_writer_ram_wren,
    output logic [RAM_COUNT*ADDR_WIDTH-1:0]          buffer_writer_ram_wr_addr,
    output logic [RAM_COUNT*LAST_Iw*DATA_WIDTH-1:0]  buffer_writer_ram_wr_data,
    output logic                                     row_err
);

    localparam int GRP_WIDTH  = (RAM_COUNT > 1) ? $clog2(RAM_COUNT) : 1;
    localparam int BEAT_WIDTH = LAST_Iw * DATA_WIDTH;
    localparam logic [GRP_WIDTH-1:0] c_GRP_LAST = GRP_WIDTH'(RAM_COUNT - 1);
    localparam logic [CH_WIDTH-1:0]  c_CH_LAST  = CH_WIDTH'(LAST_C - 1);

    wr_state_e              r_state;
    logic [GRP_WIDTH-1:0]   r_grp;
    logic [CH_WIDTH-1:0]    r_ch;
    logic                   r_wr_vld;
    logic [GRP_WIDTH-1:0]   r_wr_grp;
    logic [CH_WIDTH-1:0]    r_wr_ch;
    logic [BEAT_WIDTH-1:0]  r_wr_data;
    logic                   r_row_err;

    logic                   w_hs;
    logic                   w_last_beat;
    logic [BEAT_WIDTH-1:0]  w_masked;

    assign in_ready           = (r_state == WR_WRITE);
    assign w_hs               = in_ready && in_valid;
    assign w_last_beat        = (r_grp == c_GRP_LAST) && (r_ch == c_CH_LAST);
    assign buffer_writer_done = (r_state == WR_DONE);
    assign row_err            = r_row_err;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= WR_IDLE;
            r_grp   <= '0;
            r_ch    <= '0;
        end else begin
            case (r_state)
                WR_IDLE: begin
                    if (buffer_writer_en) begin
                        r_grp   <= '0;
                        r_ch    <= '0;
                        r_state <= WR_WRITE;
                    end
                end
                WR_WRITE: begin
                    if (w_hs) begin
                        if (w_last_beat) begin
                            r_state <= WR_FLUSH;
                        end
                        // Channel saturates at its last value instead of wrapping.
                        if (r_grp == c_GRP_LAST) begin
                            r_grp <= '0;
                            if (r_ch != c_CH_LAST) begin
                                r_ch <= r_ch + 1'b1;
                            end
                        end else begin
                            r_grp <= r_grp + 1'b1;
                        end
                    end
                end
                WR_FLUSH: r_state <= WR_DONE;
                WR_DONE:  r_state <= WR_IDLE;
                default:  r_state <= WR_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_wr_vld  <= 1'b0;
            r_wr_grp  <= '0;
            r_wr_ch   <= '0;
            r_wr_data <= '0;
            r_row_err <= 1'b0;
        end else begin
            r_wr_vld <= w_hs;
            if (w_hs) begin
                r_wr_grp  <= r_grp;
                r_wr_ch   <= r_ch;
                r_wr_data <= in_data;
                if (in_last != w_last_beat) begin
                    r_row_err <= 1'b1;
                end
            end
        end
    end

    row_pixel_mask #(
        .DATA_WIDTH (DATA_WIDTH),
        .LAST_Iw    (LAST_Iw),
        .REAL_HINT  (REAL_HINT),
        .RAM_COUNT  (RAM_COUNT),
        .GRP_WIDTH  (GRP_WIDTH)
    ) u_mask (
        .i_grp  (r_wr_grp),
        .i_data (r_wr_data),
        .o_data (w_masked)
    );

    for (genvar g = 0; g < RAM_COUNT; g++) begin : g_ram
        logic w_sel;

        assign w_sel = r_wr_vld && (r_wr_grp == GRP_WIDTH'(g));
        assign buffer_writer_ram_wren[g] = w_sel;
        assign buffer_writer_ram_wr_addr[g*ADDR_WIDTH +: ADDR_WIDTH] =
            w_sel ? {{(ADDR_WIDTH-CH_WIDTH){1'b0}}, r_wr_ch} : '0;
        assign buffer_writer_ram_wr_data[g*BEAT_WIDTH +: BEAT_WIDTH] =
            w_sel ? w_masked : '0;
    end : g_ram

endmodule
`default_nettype wire

// File: tb/tb_row_buffer_writer.sv
`default_nettype none
// ============================================================================
// Module      : tb_row_buffer_writer
// Description : Self-checking bench for row_buffer_writer (LAST_C=4,
//               LAST_Iw=7, REAL_HINT=13, two RAMs per row buffer).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_row_buffer_writer;

    localparam int DW    = 8;
    localparam int IW    = 7;
    localparam int RH    = 13;
    localparam int LC    = 4;
    localparam int AW    = 32;
    localparam int CW    = 10;
    localparam int RC    = 2;
    localparam int BEATS = LC * RC;

    logic                  clk = 1'b0;
    logic                  rstn;
    logic                  buffer_writer_en;
    logic                  buffer_writer_done;
    logic                  in_valid;
    logic                  in_ready;
    logic [IW*DW-1:0]      in_data;
    logic                  in_last;
    logic [RC-1:0]         buffer_writer_ram_wren;
    logic [RC*AW-1:0]      buffer_writer_ram_wr_addr;
    logic [RC*IW*DW-1:0]   buffer_writer_ram_wr_data;
    logic                  row_err;

    row_buffer_writer #(
        .DATA_WIDTH (DW),
        .REAL_HINT  (RH),
        .LAST_Iw    (IW),
        .LAST_C     (LC),
        .ADDR_WIDTH (AW),
        .CH_WIDTH   (CW)
    ) dut (
        .clk                       (clk),
        .rstn                      (rstn),
        .buffer_writer_en          (buffer_writer_en),
        .buffer_writer_done        (buffer_writer_done),
        .in_valid                  (in_valid),
        .in_ready                  (in_ready),
        .in_data                   (in_data),
        .in_last                   (in_last),
        .buffer_writer_ram_wren    (buffer_writer_ram_wren),
        .buffer_writer_ram_wr_addr (buffer_writer_ram_wr_addr),
        .buffer_writer_ram_wr_data (buffer_writer_ram_wr_data),
        .row_err                   (row_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int               grp;
        int               ch;
        logic [IW*DW-1:0] data;
    } exp_t;

    typedef struct {
        int dmode;
        int stall;
        int err_beat;
        int spur;
        int rst_at;
    } vec_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   n_writes = 0;
    int   n_done   = 0;
    bit   exp_err  = 1'b0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference: zero columns past the real row width, then optional ReLU.
    function automatic logic [IW*DW-1:0] f_expect(input logic [IW*DW-1:0] d, input int grp);
        logic [IW*DW-1:0] r;
        logic [DW-1:0]    p;
        r = '0;
        for (int l = 0; l < IW; l++) begin
            p = d[l*DW +: DW];
            if (grp * IW + l >= RH) p = '0;
`ifdef ROW_WRITER_RELU_EN
            if ($signed(p) < 0) p = '0;
`endif
            r[l*DW +: DW] = p;
        end
        return r;
    endfunction

    function automatic logic [IW*DW-1:0] f_make_data(input int dmode, input int k);
        logic [IW*DW-1:0] d;
        for (int l = 0; l < IW; l++) begin
            case (dmode)
                0:       d[l*DW +: DW] = DW'(k);
                1:       d[l*DW +: DW] = 8'hFF;
                3:       d[l*DW +: DW] = (l == 0) ? 8'h80 : ((l == 1) ? 8'hFE : 8'h7F);
                default: d[l*DW +: DW] = DW'($urandom_range(0, 255));
            endcase
        end
        return d;
    endfunction

    exp_t                m_e;
    logic [RC-1:0]       m_ew;
    logic [RC*AW-1:0]    m_ea;
    logic [RC*IW*DW-1:0] m_ed;

    always @(negedge clk) begin
        if (rstn) begin
            if (buffer_writer_done) n_done++;
            if (buffer_writer_ram_wren != '0) begin
                n_writes++;
                if (exp_q.size() == 0) begin
                    chk("unexpected_write", 128'(buffer_writer_ram_wren), 128'd0);
                end else begin
                    m_e  = exp_q.pop_front();
                    m_ew = '0;
                    m_ew[m_e.grp] = 1'b1;
                    m_ea = '0;
                    m_ea[m_e.grp*AW +: AW] = AW'(m_e.ch);
                    m_ed = '0;
                    m_ed[m_e.grp*IW*DW +: IW*DW] = m_e.data;
                    chk("wren", 128'(buffer_writer_ram_wren), 128'(m_ew));
                    chk("wr_addr", 128'(buffer_writer_ram_wr_addr), 128'(m_ea));
                    chk("wr_data", 128'(buffer_writer_ram_wr_data), 128'(m_ed));
                end
            end
        end
    end

    task automatic chk_all_zero(input string nm);
        chk({nm, "_wren"}, 128'(buffer_writer_ram_wren), 128'd0);
        chk({nm, "_addr"}, 128'(buffer_writer_ram_wr_addr), 128'd0);
        chk({nm, "_data"}, 128'(buffer_writer_ram_wr_data), 128'd0);
        chk({nm, "_ready"}, 128'(in_ready), 128'd0);
        chk({nm, "_done"}, 128'(buffer_writer_done), 128'd0);
        chk({nm, "_row_err"}, 128'(row_err), 128'd0);
    endtask

    task automatic run_row(input int dmode, input int stall, input int err_beat,
                           input int spur, input int rst_at);
        logic [IW*DW-1:0] d;
        exp_t             e;
        int               wr0;
        int               dn0;
        bit               got;
        wr0 = n_writes;
        dn0 = n_done;
        @(negedge clk);
        chk("ready_idle", 128'(in_ready), 128'd0);
        @(posedge clk); #1 buffer_writer_en = 1'b1;
        @(posedge clk); #1 buffer_writer_en = 1'b0;
        for (int k = 0; k < BEATS; k++) begin
            if (stall != 0 && (k % 2) == 1) begin
                in_valid = 1'b0;
                if (spur != 0 && k == 3) buffer_writer_en = 1'b1;
                @(posedge clk); #1 buffer_writer_en = 1'b0;
            end
            d        = f_make_data(dmode, k);
            in_data  = d;
            in_valid = 1'b1;
            in_last  = (k == BEATS - 1) || (k == err_beat);
            got      = 1'b0;
            for (int t = 0; t < 20; t++) begin
                @(negedge clk);
                if (in_ready) begin
                    got = 1'b1;
                    break;
                end
            end
            if (!got) begin
                chk("ready_timeout", 128'd0, 128'd1);
                in_valid = 1'b0;
                return;
            end
            @(posedge clk); #1;
            e.grp  = k % RC;
            e.ch   = k / RC;
            e.data = f_expect(d, e.grp);
            exp_q.push_back(e);
            if (in_last != (k == BEATS - 1)) exp_err = 1'b1;
            in_valid = 1'b0;
            in_last  = 1'b0;
            if (k == rst_at) begin
                rstn = 1'b0;
                exp_q.delete();
                exp_err = 1'b0;
                @(negedge clk);
                chk_all_zero("mid_reset");
                rstn = 1'b1;
                repeat (5) @(negedge clk);
                chk("reset_no_done", 128'(n_done - dn0), 128'd0);
                chk("reset_ready", 128'(in_ready), 128'd0);
                return;
            end
        end
        @(negedge clk);
        chk("ready_after_last", 128'(in_ready), 128'd0);
        chk("done_early", 128'(buffer_writer_done), 128'd0);
        @(negedge clk);
        chk("done_pulse", 128'(buffer_writer_done), 128'd1);
        chk("ready_in_done", 128'(in_ready), 128'd0);
        @(negedge clk);
        chk("done_low", 128'(buffer_writer_done), 128'd0);
        chk("write_count", 128'(n_writes - wr0), 128'(BEATS));
        chk("done_count", 128'(n_done - dn0), 128'd1);
        chk("queue_empty", 128'(exp_q.size()), 128'd0);
        chk("row_err", 128'(row_err), 128'(exp_err));
    endtask

    vec_t vecs[8];

    initial begin
        vecs[0] = '{dmode: 0, stall: 0, err_beat: -1, spur: 0, rst_at: -1};
        vecs[1] = '{dmode: 1, stall: 0, err_beat: -1, spur: 0, rst_at: -1};
        vecs[2] = '{dmode: 0, stall: 1, err_beat: -1, spur: 1, rst_at: -1};
        vecs[3] = '{dmode: 3, stall: 0, err_beat: -1, spur: 0, rst_at: -1};
        vecs[4] = '{dmode: 2, stall: 1, err_beat: -1, spur: 0, rst_at: -1};
        vecs[5] = '{dmode: 2, stall: 0, err_beat:  3, spur: 0, rst_at: -1};
        vecs[6] = '{dmode: 0, stall: 0, err_beat: -1, spur: 0, rst_at:  4};
        vecs[7] = '{dmode: 0, stall: 0, err_beat: -1, spur: 0, rst_at: -1};

        rstn             = 1'b0;
        buffer_writer_en = 1'b0;
        in_valid         = 1'b0;
        in_data          = '0;
        in_last          = 1'b0;
        repeat (2) @(negedge clk);
        chk_all_zero("reset");
        rstn = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 8; i++) begin
            run_row(vecs[i].dmode, vecs[i].stall, vecs[i].err_beat, vecs[i].spur, vecs[i].rst_at);
        end

        for (int i = 0; i < 3; i++) begin
            run_row(2, int'($urandom_range(0, 1)), -1, 0, -1);
        end

        // Explicit feature check on lane 0 of a 0x80 pixel in group 0.
        in_data = '0;
        run_row(3, 0, -1, 0, -1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got timeout expected finish");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
